// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift sequencer and the register integration top.
//   seq_state_e : sequencer FSM state encoding
//   MODE_*      : mode-select codes understood by the 8-bit shift register
//   shift_mode  : picks the shift mode code from a direction bit
package shift_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_LOAD = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_SHR  = 2'b11;

  function automatic logic [1:0] shift_mode(input logic dir);
    return dir ? MODE_SHR : MODE_SHL;
  endfunction

endpackage

// File: rtl/shift_seq_cnt.sv
// Remaining-shift counter for the shift sequencer.
//   clk, rst_n : clock, async active-low reset
//   load_i     : load count_i (clamped to WIDTH)
//   count_i    : requested shift count
//   en_i       : decrement by one (saturates at zero)
//   zero_o     : counter is zero
module shift_seq_cnt #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic             en_i,
  output logic             zero_o
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(WIDTH);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = (count_i > MAX_CNT) ? MAX_CNT : count_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/shift_sequencer.sv
// Control stage for the 8-bit parallel-load shift register: accepts a byte
// and shift command, then issues one load cycle and N shift cycles.
//   clk, rst_n           : clock, async active-low reset
//   data_i, count_i      : byte to load, number of shifts (clamped to WIDTH)
//   dir_i, fill_i        : shift direction (1 = right), serial fill bit
//   valid_i / ready_o    : command handshake
//   hold_i               : stall, freezes shifting
//   S_o, data_o          : register mode select and parallel data
//   data_L_o, data_R_o   : MSB fill (right shift) / LSB fill (left shift)
//   busy_o, done_o       : command in progress / one-cycle completion pulse
//
// state | meaning
// IDLE  | ready for a command, register held
// LOAD  | one cycle of parallel load of the captured byte
// SHIFT | shift cycles; hold_i inserts hold cycles without consuming count
// DONE  | one-cycle done pulse, then back to IDLE
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic             dir_i,
  input  logic             fill_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             hold_i,
  output logic [1:0]       S_o,
  output logic [WIDTH-1:0] data_o,
  output logic             data_L_o,
  output logic             data_R_o,
  output logic             busy_o,
  output logic             done_o
);

  seq_state_e       state_q, state_d;
  logic [1:0]       s_q, s_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             dir_q, dir_d;
  logic             fill_q, fill_d;
  logic             data_l_q, data_l_d;
  logic             data_r_q, data_r_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept;
  logic             cnt_en;
  logic             cnt_zero;

  // The counter holds shifts still to be issued; it is decremented on the
  // edge that starts each shift cycle, so zero in SHIFT means the last shift
  // is the one currently on S_o.
  shift_seq_cnt #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (accept),
    .count_i (count_i),
    .en_i    (cnt_en),
    .zero_o  (cnt_zero)
  );

  always_comb begin
    state_d = state_q;
    s_d     = MODE_HOLD;
    data_d  = data_q;
    dir_d   = dir_q;
    fill_d  = fill_q;
    done_d  = 1'b0;
    accept  = 1'b0;
    cnt_en  = 1'b0;

    case (state_q)
      IDLE: begin
        if (valid_i) begin
          accept  = 1'b1;
          data_d  = data_i;
          dir_d   = dir_i;
          fill_d  = fill_i;
          state_d = LOAD;
          s_d     = MODE_LOAD;
        end
      end
      LOAD: begin
        // hold_i is not looked at here: the first shift always follows LOAD
        if (cnt_zero) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = SHIFT;
          s_d     = shift_mode(dir_q);
          cnt_en  = 1'b1;
        end
      end
      SHIFT: begin
        if (cnt_zero) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (!hold_i) begin
          s_d    = shift_mode(dir_q);
          cnt_en = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    data_l_d = (state_d == SHIFT) &&  dir_q && fill_q;
    data_r_d = (state_d == SHIFT) && !dir_q && fill_q;
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      s_q      <= MODE_HOLD;
      data_q   <= '0;
      dir_q    <= 1'b0;
      fill_q   <= 1'b0;
      data_l_q <= 1'b0;
      data_r_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      data_q   <= data_d;
      dir_q    <= dir_d;
      fill_q   <= fill_d;
      data_l_q <= data_l_d;
      data_r_q <= data_r_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign ready_o  = (state_q == IDLE);
  assign S_o      = s_q;
  assign data_o   = data_q;
  assign data_L_o = data_l_q;
  assign data_R_o = data_r_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;

endmodule
